fetch_sequencer: RTL

- Instruction fetch controller between the instruction memory and decode.
- Owns the program counter and drives the memory's word address (asynchronous read, data valid in the same cycle).
- Registers each fetched word into an instruction register and hands it to decode over a valid/ready handshake.
- Accepts redirects (jump/branch targets) from execute, detects the halt opcode, and flags out-of-range fetches.

---
 rtl/processor_pkg.sv | 23 ++
 rtl/fetch_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/processor_pkg.sv
// Shared processor definitions: instruction opcode field, opcode values and
// the fetch controller state encoding.
package processor_pkg;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 27;
    localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

    localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b00100;
    localparam logic [OPCODE_W-1:0] OP_HALT = 5'b00110;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [31:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: owns the PC, captures memory words into an
// instruction register and hands them to decode over a valid/ready handshake.
module fetch_sequencer
    import processor_pkg::*;
#(
    parameter logic [31:0]         RESET_PC    = 32'd0,
    parameter int unsigned         MEM_DEPTH   = 31,
    parameter logic [OPCODE_W-1:0] HALT_OPCODE = OP_HALT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] instruction_address,
    input  logic [31:0] instruction_data,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_address,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] PC_LIMIT = 32'(MEM_DEPTH);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  instr_out_reg, instr_out_next;
    logic [31:0]  instr_pc_reg, instr_pc_next;
    logic         instr_valid_reg, instr_valid_next;
    logic         halted_reg, halted_next;
    logic         fault_reg, fault_next;
    logic [31:0]  fetch_count_reg, fetch_count_next;

    logic take;
    logic slot_free;
    logic out_of_range;
    logic is_halt;

    assign take         = instr_valid_reg & instr_ready;
    assign slot_free    = ~instr_valid_reg | instr_ready;
    assign out_of_range = (pc_reg >= PC_LIMIT);
    assign is_halt      = (opcode_of(instruction_data) == HALT_OPCODE);

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            pc_reg          <= RESET_PC;
            instr_out_reg   <= 32'd0;
            instr_pc_reg    <= 32'd0;
            instr_valid_reg <= 1'b0;
            halted_reg      <= 1'b0;
            fault_reg       <= 1'b0;
            fetch_count_reg <= 32'd0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            instr_out_reg   <= instr_out_next;
            instr_pc_reg    <= instr_pc_next;
            instr_valid_reg <= instr_valid_next;
            halted_reg      <= halted_next;
            fault_reg       <= fault_next;
            fetch_count_reg <= fetch_count_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                if (redirect_valid)              state_next = RUN;
                else if (out_of_range)           state_next = HALTED;
                else if (slot_free && is_halt)   state_next = DRAIN;
            end
            DRAIN: begin
                if (redirect_valid) state_next = RUN;
                else if (take)      state_next = HALTED;
            end
            HALTED: begin
                if (start) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath next values, keyed on the current state
    always_comb begin
        pc_next          = pc_reg;
        instr_out_next   = instr_out_reg;
        instr_pc_next    = instr_pc_reg;
        instr_valid_next = instr_valid_reg;
        halted_next      = halted_reg;
        fault_next       = fault_reg;
        fetch_count_next = fetch_count_reg;
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    pc_next          = RESET_PC;
                    fetch_count_next = 32'd0;
                end
            end
            RUN: begin
                if (redirect_valid) begin
                    // Flush even if decode takes the held word this cycle.
                    pc_next          = redirect_address;
                    instr_valid_next = 1'b0;
                end else if (out_of_range) begin
                    if (take) instr_valid_next = 1'b0;
                    fault_next  = 1'b1;
                    halted_next = 1'b1;
                end else if (slot_free) begin
                    instr_out_next   = instruction_data;
                    instr_pc_next    = pc_reg;
                    instr_valid_next = 1'b1;
                    fetch_count_next = fetch_count_reg + 32'd1;
                    if (!is_halt) pc_next = pc_reg + 32'd1;
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    pc_next          = redirect_address;
                    instr_valid_next = 1'b0;
                end else if (take) begin
                    instr_valid_next = 1'b0;
                    halted_next      = 1'b1;
                end
            end
            HALTED: begin
                // A word still held when a fault stopped fetch may drain out.
                if (take) instr_valid_next = 1'b0;
                if (start) begin
                    pc_next          = RESET_PC;
                    instr_valid_next = 1'b0;
                    halted_next      = 1'b0;
                    fault_next       = 1'b0;
                    fetch_count_next = 32'd0;
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        instruction_address = pc_reg;
        instr_out           = instr_out_reg;
        instr_pc            = instr_pc_reg;
        instr_valid         = instr_valid_reg;
        halted              = halted_reg;
        fault               = fault_reg;
        fetch_count         = fetch_count_reg;
    end

endmodule
